fft_frame_collector: RTL and testbench
======================================

// Module: fft_frame_collector
// PURPOSE
//  Upstream feeder for the 16-point FFT. Takes bytes from the UART receiver (one-cycle valid strobe),
//  converts each to a signed fixed-point real sample, assembles FFT_SIZE samples into a frame buffer,
//  and presents the whole frame to the FFT core with a valid/ready handshake.
//  Flushes stale partial frames on an inter-byte timeout. Reports dropped bytes.
// PARAMETERS
//  FFT_SIZE        16      samples per frame; power of 2, >= 2
//  WORD_SIZE       16      sample width, two's complement
//  DATA_LENGTH     8       received byte width
//  FRACTION        8       fractional bits of sample; WORD_SIZE >= DATA_LENGTH + FRACTION required
//  TIMEOUT_CYCLES  100000  idle i_clk cycles before a partial frame is discarded; >= 2
// PORTS
//  i_clk           in   1                    clock
//  i_rst           in   1                    reset, asynchronous, active-high
//  i_byte          in   DATA_LENGTH          received byte, valid only with i_byte_valid
//  i_byte_valid    in   1                    one-cycle strobe per received byte
//  i_frame_ready   in   1                    FFT core can accept frame
//  o_frame_valid   out  1                    full frame held on o_samples
//  o_samples       out  FFT_SIZE*WORD_SIZE   sample k at [k*WORD_SIZE +: WORD_SIZE], k=0 first received
//  o_count         out  clog2(FFT_SIZE)+1    samples currently held (0..FFT_SIZE)
//  o_overrun       out  1                    one-cycle pulse: byte dropped
//  o_timeout       out  1                    one-cycle pulse: partial frame discarded
// BEHAVIOUR
//  Reset (async assert, sync release): state COLLECT, o_count=0, o_samples=0, o_frame_valid=0,
//   o_overrun=0, o_timeout=0, idle timer=0.
//  Conversion: byte treated as signed; sample = sign_extend(byte, WORD_SIZE-FRACTION) << FRACTION.
//   WORD_SIZE=16,FRACTION=8: 0x7F->0x7F00, 0x80->0x8000, 0x01->0x0100.
//  State COLLECT: on i_byte_valid write converted sample to slot o_count, o_count+=1, timer=0.
//   When the write fills slot FFT_SIZE-1: next cycle state FULL, o_frame_valid=1, o_count=FFT_SIZE.
//   Latency: o_frame_valid rises 1 cycle after the edge sampling the last byte strobe.
//  Idle timer: counts only in COLLECT with o_count>0 and no strobe; on reaching TIMEOUT_CYCLES:
//   o_count=0, timer=0, o_timeout pulses 1 cycle; buffer contents not cleared (overwritten later).
//   Strobe in the expiry cycle: byte wins, accepted, timer=0, no timeout.
//   o_count=0: timer held at 0, never times out.
//  State FULL: o_samples and o_frame_valid stable until handshake. Any i_byte_valid without
//   handshake in same cycle: byte dropped, o_overrun pulses next cycle, buffer unchanged.
//  Handshake (o_frame_valid & i_frame_ready at edge): next cycle state COLLECT, o_frame_valid=0,
//   o_count=0. i_byte_valid in the handshake cycle: accepted as sample 0 of next frame
//   (o_count=1 next cycle), no overrun. i_frame_ready while not valid: ignored.
//  o_frame_valid never drops without handshake except by reset. Reset mid-frame or mid-FULL:
//   frame lost, all outputs to reset values immediately.
//  Outputs registered; no combinational path from inputs to outputs.
// TESTING
//  1 Send 0x01..0x10 (16 strobes, 10-cycle spacing), ready=0 -> o_frame_valid=1 one cycle after last,
//    sample k = (k+1)<<8 (0x0100..0x1000), o_count=16; hold ready=0 100 cycles -> all stable.
//  2 Bytes 0x7F,0x80,0xFF,0x00 then 12x0x00 -> samples 0x7F00,0x8000,0xFF00,0x0000,...
//  3 5 bytes then idle TIMEOUT_CYCLES (bench TIMEOUT_CYCLES=50) -> o_timeout 1-cycle pulse, o_count=0;
//    then 16 bytes 0x20.. -> frame valid with sample0=0x2000 (old data not leaked).
//  4 Frame FULL, ready=0, send 0xAA -> o_overrun pulse, samples unchanged; ready=1 -> valid drops,
//    o_count=0.
//  5 Frame FULL, ready=1 and strobe 0x05 same cycle -> valid=0, o_count=1, sample0=0x0500, no overrun.
//  6 Assert i_rst asynchronously after 7 bytes and again in FULL -> outputs zero without clock edge;
//    after release, fresh 16-byte frame completes normally.

Source files
------------

// File: rtl/fft_frame_collector.sv
// Byte-stream to FFT frame collector: converts received bytes to fixed-point
// samples, assembles a frame, hands it off with valid/ready, flushes on idle.
module fft_frame_collector #(
  parameter int FFT_SIZE       = 16,
  parameter int WORD_SIZE      = 16,
  parameter int DATA_LENGTH    = 8,
  parameter int FRACTION       = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [DATA_LENGTH-1:0]        i_byte,
  input  logic                          i_byte_valid,
  input  logic                          i_frame_ready,
  output logic                          o_frame_valid,
  output logic [FFT_SIZE*WORD_SIZE-1:0] o_samples,
  output logic [$clog2(FFT_SIZE):0]     o_count,
  output logic                          o_overrun,
  output logic                          o_timeout
);

  localparam int CW = $clog2(FFT_SIZE) + 1;
  localparam int AW = $clog2(FFT_SIZE);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {COLLECT, FULL} state_t;

  state_t               state, state_n;
  logic [WORD_SIZE-1:0] mem   [FFT_SIZE];
  logic [WORD_SIZE-1:0] mem_n [FFT_SIZE];
  logic [CW-1:0]        count, count_n;
  logic [TW-1:0]        timer, timer_n;
  logic                 overrun, overrun_n;
  logic                 timeout, timeout_n;
  logic [WORD_SIZE-1:0] ext;
  logic [WORD_SIZE-1:0] conv;
  logic [AW-1:0]        slot;

  // Sign-extend the raw byte, then scale it into the integer part.
  assign ext  = WORD_SIZE'($signed(i_byte));
  assign conv = ext << FRACTION;
  assign slot = count[AW-1:0];

  always_comb begin
    state_n   = state;
    mem_n     = mem;
    count_n   = count;
    timer_n   = timer;
    overrun_n = 1'b0;
    timeout_n = 1'b0;
    unique case (state)
      COLLECT: begin
        if (i_byte_valid) begin
          mem_n[slot] = conv;
          timer_n     = '0;
          count_n     = count + CW'(1);
          if (count == CW'(FFT_SIZE - 1))
            state_n = FULL;
        end else if (count != '0) begin
          if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            count_n   = '0;
            timer_n   = '0;
            timeout_n = 1'b1;
          end else begin
            timer_n = timer + TW'(1);
          end
        end else begin
          timer_n = '0;
        end
      end
      FULL: begin
        if (i_frame_ready) begin
          state_n = COLLECT;
          count_n = '0;
          timer_n = '0;
          // A byte landing on the handshake starts the next frame.
          if (i_byte_valid) begin
            mem_n[0] = conv;
            count_n  = CW'(1);
          end
        end else if (i_byte_valid) begin
          overrun_n = 1'b1;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= COLLECT;
      count   <= '0;
      timer   <= '0;
      overrun <= 1'b0;
      timeout <= 1'b0;
      for (int k = 0; k < FFT_SIZE; k++)
        mem[k] <= '0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      timer   <= timer_n;
      overrun <= overrun_n;
      timeout <= timeout_n;
      mem     <= mem_n;
    end
  end

  for (genvar k = 0; k < FFT_SIZE; k++) begin : g_pack
    assign o_samples[k*WORD_SIZE +: WORD_SIZE] = mem[k];
  end

  assign o_frame_valid = (state == FULL);
  assign o_count       = count;
  assign o_overrun     = overrun;
  assign o_timeout     = timeout;

endmodule

// File: tb/tb_fft_frame_collector.sv
// Directed bench for fft_frame_collector: frame fill, conversion, timeout,
// overrun, handshake-with-byte and asynchronous reset.
module tb_fft_frame_collector;

  logic         clk;
  logic         rst;
  logic [7:0]   b;
  logic         bv;
  logic         rdy;
  logic         fv;
  logic [255:0] smp_bus;
  logic [4:0]   cnt;
  logic         ovr;
  logic         tmo;

  int n_checks = 0;
  int n_fail   = 0;

  fft_frame_collector #(
    .FFT_SIZE(16), .WORD_SIZE(16), .DATA_LENGTH(8),
    .FRACTION(8), .TIMEOUT_CYCLES(50)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_byte(b), .i_byte_valid(bv),
    .i_frame_ready(rdy), .o_frame_valid(fv), .o_samples(smp_bus),
    .o_count(cnt), .o_overrun(ovr), .o_timeout(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] smp(input int k);
    return smp_bus[k*16 +: 16];
  endfunction

  task automatic send(input logic [7:0] v, input int gap);
    @(negedge clk);
    b  = v;
    bv = 1'b1;
    @(negedge clk);
    bv = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic handshake();
    @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 16; i++)
      send(base + 8'(i), 0);
  endtask

  initial begin
    int hit;
    logic [7:0] v;
    rst = 1'b1;
    b   = '0;
    bv  = 1'b0;
    rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", cnt, 0);
    check("rst_valid", fv, 0);
    check("rst_samples", 32'(smp_bus != '0), 0);
    check("rst_ovr_tmo", {ovr, tmo}, 0);
    rst = 1'b0;

    // Frame of 0x01..0x10 with spaced strobes
    for (int i = 0; i < 15; i++)
      send(8'(i + 1), 9);
    check("t1_valid_early", fv, 0);
    check("t1_count15", cnt, 15);
    send(8'h10, 0);
    check("t1_valid", fv, 1);
    check("t1_count16", cnt, 16);
    for (int k = 0; k < 16; k++)
      check($sformatf("t1_s%0d", k), smp(k), 32'((k + 1) << 8));
    repeat (100) @(negedge clk);
    check("t1_hold_valid", fv, 1);
    check("t1_hold_s0", smp(0), 32'h0100);
    check("t1_hold_s15", smp(15), 32'h1000);
    handshake();
    check("t1_release_valid", fv, 0);
    check("t1_release_count", cnt, 0);

    // Sign conversion corners
    send(8'h7F, 0);
    send(8'h80, 0);
    send(8'hFF, 0);
    for (int i = 0; i < 13; i++)
      send(8'h00, 0);
    check("t2_valid", fv, 1);
    check("t2_s0", smp(0), 32'h7F00);
    check("t2_s1", smp(1), 32'h8000);
    check("t2_s2", smp(2), 32'hFF00);
    check("t2_s3", smp(3), 32'h0000);
    check("t2_s15", smp(15), 32'h0000);
    handshake();

    // Idle timeout discards a partial frame
    for (int i = 0; i < 5; i++)
      send(8'h11 + 8'(i), 0);
    check("t3_count5", cnt, 5);
    hit = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (tmo) begin
        hit = i;
        break;
      end
    end
    check("t3_timeout_cycle", hit, 50);
    check("t3_count0", cnt, 0);
    @(negedge clk);
    check("t3_pulse_end", tmo, 0);
    fill(8'h20);
    check("t3_valid", fv, 1);
    check("t3_s0", smp(0), 32'h2000);
    check("t3_s4", smp(4), 32'h2400);
    check("t3_s15", smp(15), 32'h2F00);

    // Overrun while FULL
    send(8'hAA, 0);
    check("t4_overrun", ovr, 1);
    check("t4_s0", smp(0), 32'h2000);
    check("t4_s15", smp(15), 32'h2F00);
    check("t4_valid", fv, 1);
    @(negedge clk);
    check("t4_ovr_pulse", ovr, 0);
    handshake();
    check("t4_release_valid", fv, 0);
    check("t4_release_count", cnt, 0);

    // Byte on handshake cycle starts next frame
    fill(8'h30);
    check("t5_full", fv, 1);
    @(negedge clk);
    rdy = 1'b1;
    b   = 8'h05;
    bv  = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    bv  = 1'b0;
    check("t5_valid", fv, 0);
    check("t5_count", cnt, 1);
    check("t5_s0", smp(0), 32'h0500);
    check("t5_ovr", ovr, 0);

    // Asynchronous reset mid-collect and while FULL
    for (int i = 0; i < 6; i++)
      send(8'h60, 0);
    check("t6_count7", cnt, 7);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_count", cnt, 0);
    check("t6_rst_samples", 32'(smp_bus != '0), 0);
    @(negedge clk);
    rst = 1'b0;
    fill(8'h50);
    check("t6_full", fv, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", fv, 0);
    check("t6_rst_count2", cnt, 0);
    check("t6_rst_samples2", 32'(smp_bus != '0), 0);
    @(negedge clk);
    rst = 1'b0;
    v = 8'h40;
    fill(v);
    check("t6_valid", fv, 1);
    check("t6_count", cnt, 16);
    check("t6_s0", smp(0), 32'h4000);
    check("t6_s15", smp(15), 32'h4F00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
